// File: rtl/axis_input_loader.sv
// rtl/axis_input_loader.sv - AXI-Stream input loader filling kernel (W) and image (X) buffers
module axis_input_loader #(
  parameter int INW = 12,
  parameter int R   = 3,
  parameter int N   = 8,
  localparam int XADDRW = (N*N > 1) ? $clog2(N*N) : 1,
  localparam int WADDRW = (R*R > 1) ? $clog2(R*R) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INW-1:0]    IN_AXIS_TDATA,
  input  logic              IN_AXIS_TVALID,
  input  logic              IN_AXIS_TUSER,
  output logic              IN_AXIS_TREADY,
  output logic              inputs_loaded,
  input  logic              compute_finished,
  input  logic [XADDRW-1:0] x_read_addr,
  output logic [INW-1:0]    x_data,
  input  logic [WADDRW-1:0] w_read_addr,
  output logic [INW-1:0]    w_data
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_X = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [WADDRW-1:0] W_LAST = WADDRW'(R*R - 1);
  localparam logic [XADDRW-1:0] X_LAST = XADDRW'(N*N - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WADDRW-1:0]   r_w_cnt;
  logic [WADDRW-1:0]   w_w_cnt_nxt;
  logic [XADDRW-1:0]   r_x_cnt;
  logic [XADDRW-1:0]   w_x_cnt_nxt;

  logic                w_hs;
  logic                w_w_we;
  logic [WADDRW-1:0]   w_w_waddr;
  logic                w_x_we;
  logic [XADDRW-1:0]   w_x_waddr;

  logic [INW-1:0]      r_w_mem [R*R];
  logic [INW-1:0]      r_x_mem [N*N];
  logic [INW-1:0]      r_x_data;
  logic [INW-1:0]      r_w_data;

  // Ready and loaded are pure functions of state so upstream never sees a TVALID->TREADY path.
  assign IN_AXIS_TREADY = (r_state != ST_DONE);
  assign inputs_loaded  = (r_state == ST_DONE);
  assign w_hs           = IN_AXIS_TVALID && IN_AXIS_TREADY;
  assign x_data         = r_x_data;
  assign w_data         = r_w_data;

  // State and counter registers; reset abandons any partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_START;
      r_w_cnt <= '0;
      r_x_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_w_cnt <= w_w_cnt_nxt;
      r_x_cnt <= w_x_cnt_nxt;
    end
  end

  // Next-state, counter and buffer write decode; TUSER only matters on a packet's first word.
  always_comb begin
    w_state_nxt = r_state;
    w_w_cnt_nxt = r_w_cnt;
    w_x_cnt_nxt = r_x_cnt;
    w_w_we      = 1'b0;
    w_w_waddr   = r_w_cnt;
    w_x_we      = 1'b0;
    w_x_waddr   = r_x_cnt;
    case (r_state)
      ST_START: begin
        if (w_hs) begin
          if (IN_AXIS_TUSER) begin
            w_w_we    = 1'b1;
            w_w_waddr = '0;
            if (R*R == 1) begin
              w_state_nxt = ST_LOAD_X;
              w_x_cnt_nxt = '0;
            end else begin
              w_state_nxt = ST_LOAD_W;
              w_w_cnt_nxt = WADDRW'(1);
            end
          end else begin
            w_x_we    = 1'b1;
            w_x_waddr = '0;
            if (N*N == 1) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_LOAD_X;
              w_x_cnt_nxt = XADDRW'(1);
            end
          end
        end
      end
      ST_LOAD_W: begin
        if (w_hs) begin
          w_w_we = 1'b1;
          if (r_w_cnt == W_LAST) begin
            w_state_nxt = ST_LOAD_X;
            w_x_cnt_nxt = '0;
          end else begin
            w_w_cnt_nxt = r_w_cnt + WADDRW'(1);
          end
        end
      end
      ST_LOAD_X: begin
        if (w_hs) begin
          w_x_we = 1'b1;
          if (r_x_cnt == X_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_x_cnt_nxt = r_x_cnt + XADDRW'(1);
          end
        end
      end
      ST_DONE: begin
        if (compute_finished) begin
          w_state_nxt = ST_START;
          w_w_cnt_nxt = '0;
          w_x_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ST_START;
    endcase
    if (reset) begin
      w_w_we = 1'b0;
      w_x_we = 1'b0;
    end
  end

  // Buffer writes; contents survive reset so a TUSER=0 packet can reuse the last kernel.
  always_ff @(posedge clk) begin
    if (w_w_we) r_w_mem[w_w_waddr] <= IN_AXIS_TDATA;
    if (w_x_we) r_x_mem[w_x_waddr] <= IN_AXIS_TDATA;
  end

  // Registered reads, always enabled; a same-edge write to the read address returns old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_data <= '0;
      r_w_data <= '0;
    end else begin
      r_x_data <= r_x_mem[x_read_addr];
      r_w_data <= r_w_mem[w_read_addr];
    end
  end

endmodule

// File: tb/tb_axis_input_loader.sv
// tb/tb_axis_input_loader.sv - self-checking bench for axis_input_loader
module tb_axis_input_loader;
  localparam int INW = 12;
  localparam int R   = 3;
  localparam int N   = 8;
  localparam int RR  = R*R;
  localparam int NN  = N*N;

  logic           clk = 1'b0;
  logic           reset;
  logic [INW-1:0] tdata;
  logic           tvalid;
  logic           tuser;
  logic           tready;
  logic           inputs_loaded;
  logic           compute_finished;
  logic [5:0]     x_read_addr;
  logic [INW-1:0] x_data;
  logic [3:0]     w_read_addr;
  logic [INW-1:0] w_data;

  axis_input_loader #(.INW(INW), .R(R), .N(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .IN_AXIS_TDATA    (tdata),
    .IN_AXIS_TVALID   (tvalid),
    .IN_AXIS_TUSER    (tuser),
    .IN_AXIS_TREADY   (tready),
    .inputs_loaded    (inputs_loaded),
    .compute_finished (compute_finished),
    .x_read_addr      (x_read_addr),
    .x_data           (x_data),
    .w_read_addr      (w_read_addr),
    .w_data           (w_data)
  );

  always #5 clk = ~clk;

  int mw [RR];
  int mx [NN];
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit is_w;
    int addr;
    int expv;
  } rd_vec_t;

  rd_vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic scan_all(input string name);
    int errs;
    errs = 0;
    tvalid = 1'b0;
    for (int i = 0; i < NN; i++) begin
      x_read_addr = 6'(i);
      w_read_addr = 4'(i % RR);
      step();
      if (int'(x_data) != mx[i]) errs++;
      if (int'(w_data) != mw[i % RR]) errs++;
    end
    chk(name, errs, 0);
  endtask

  task automatic release_bufs();
    compute_finished = 1'b1;
    step();
    compute_finished = 1'b0;
    chk("release_loaded_low", int'(inputs_loaded), 0);
    chk("release_tready_high", int'(tready), 1);
  endtask

  task automatic send_packet(input bit with_w, input int wbase, input int xbase,
                             input bit gaps, input int cf_at, input bit chk10,
                             output int hs_cnt, output int cycles);
    int words [RR+NN];
    int total, xoff, idx, new10;
    bit done, early, hs, wrote10, pend10, cf_sent;
    total = with_w ? RR + NN : NN;
    xoff  = with_w ? RR : 0;
    for (int i = 0; i < total; i++)
      words[i] = (with_w && i < RR) ? wbase + i : xbase + (i - xoff);
    hs_cnt = 0; cycles = 0; idx = 0; new10 = 0;
    done = 0; early = 0; pend10 = 0; cf_sent = 0;
    if (chk10) x_read_addr = 6'd10;
    while (!done && cycles < 2000) begin
      tvalid = (idx < total) && (!gaps || $urandom_range(0, 1) == 1);
      tdata  = INW'(words[(idx < total) ? idx : 0]);
      tuser  = (idx == 0) ? with_w : 1'($urandom_range(0, 1));
      compute_finished = 1'b0;
      if (cf_at >= 0 && idx == cf_at && !cf_sent) begin
        compute_finished = 1'b1;
        cf_sent = 1;
      end
      hs      = tvalid && tready;
      wrote10 = chk10 && hs && (idx == xoff + 10);
      step();
      cycles++;
      if (pend10) begin
        chk("same_addr_new_data", int'(x_data), new10);
        pend10 = 0;
      end
      if (wrote10) begin
        chk("same_addr_old_data", int'(x_data), mx[10]);
        new10  = words[idx];
        pend10 = 1;
      end
      if (hs) begin
        if (idx < xoff) mw[idx] = words[idx];
        else mx[idx - xoff] = words[idx];
        idx++;
        hs_cnt++;
        if (idx == total) begin
          chk("loaded_after_last", int'(inputs_loaded), 1);
          chk("tready_low_in_done", int'(tready), 0);
          done = 1;
        end
      end
      if (!done && inputs_loaded) early = 1;
    end
    tvalid = 1'b0;
    compute_finished = 1'b0;
    if (!done) chk("packet_timeout", 0, 1);
    chk("no_early_loaded", int'(early), 0);
  endtask

  initial begin
    int hs, cyc, stall;
    for (int i = 0; i < RR; i++) mw[i] = 0;
    for (int i = 0; i < NN; i++) mx[i] = 0;
    tbl[0] = '{1'b1, 4, 5};
    tbl[1] = '{1'b0, 63, 163};
    tbl[2] = '{1'b1, 0, 1};
    tbl[3] = '{1'b1, 8, 9};
    tbl[4] = '{1'b0, 0, 100};
    tbl[5] = '{1'b0, 10, 110};

    reset = 1'b1; tvalid = 1'b0; tuser = 1'b0; tdata = '0;
    compute_finished = 1'b0; x_read_addr = '0; w_read_addr = '0;
    step();
    step();
    chk("reset_tready", int'(tready), 1);
    chk("reset_loaded", int'(inputs_loaded), 0);
    chk("reset_x_data", int'(x_data), 0);
    chk("reset_w_data", int'(w_data), 0);
    reset = 1'b0;

    send_packet(1, 1, 100, 0, -1, 0, hs, cyc);
    chk("pkt1_handshakes", hs, 73);
    chk("pkt1_consecutive", cyc, 73);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].is_w) begin
        w_read_addr = 4'(tbl[i].addr);
        step();
        chk($sformatf("tbl_w_addr%0d", tbl[i].addr), int'(w_data), tbl[i].expv);
      end else begin
        x_read_addr = 6'(tbl[i].addr);
        step();
        chk($sformatf("tbl_x_addr%0d", tbl[i].addr), int'(x_data), tbl[i].expv);
      end
    end

    tvalid = 1'b1;
    tdata  = 12'd999;
    tuser  = 1'b1;
    stall  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tready || !inputs_loaded) stall++;
    end
    tvalid = 1'b0;
    chk("done_holds_off", stall, 0);
    scan_all("done_buffers_frozen");
    release_bufs();

    send_packet(0, 0, 200, 0, -1, 0, hs, cyc);
    chk("pkt2_handshakes", hs, 64);
    scan_all("pkt2_w_reuse_scan");
    release_bufs();

    send_packet(1, 1, 100, 1, -1, 0, hs, cyc);
    chk("gap_handshakes", hs, 73);
    scan_all("gap_scan");
    release_bufs();

    tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tdata = 12'(11 + i);
      tuser = (i == 0);
      step();
      mw[i] = 11 + i;
    end
    tvalid = 1'b0;
    reset  = 1'b1;
    step();
    chk("midreset_tready", int'(tready), 1);
    chk("midreset_loaded", int'(inputs_loaded), 0);
    chk("midreset_x_data", int'(x_data), 0);
    reset = 1'b0;

    send_packet(1, 11, 300, 0, RR + 20, 1, hs, cyc);
    chk("pkt4_handshakes", hs, 73);
    scan_all("pkt4_scan");
    release_bufs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
